ils_instr_decoder: RTL and testbench



---
 rtl/ils_instr_decoder.sv | 233 +++++++++++++++++++++++
 tb/tb_ils_instr_decoder.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ils_instr_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ils_instr_decoder
// Brief    : Decodes the I-type ALU, load and store encodings of the
//            instruction stream. Records pass through a 2-entry output FIFO,
//            and each class has a saturating retire counter.
//            Optional macro ILS_DEC_NOP_FILTER_EN drops canonical NOPs at
//            the input and counts them on cnt_nop.
// Revision : 1.0 - initial release
// ============================================================================
module ils_instr_decoder #(
   parameter int CNT_W     = 16,
   parameter int BUF_DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       out_class,
   output logic [4:0]       out_rd,
   output logic [4:0]       out_rs1,
   output logic [4:0]       out_rs2,
   output logic [2:0]       out_funct3,
   output logic [31:0]      out_imm,
`ifdef ILS_DEC_NOP_FILTER_EN
   output logic [CNT_W-1:0] cnt_nop,
`endif
   output logic [CNT_W-1:0] cnt_alu,
   output logic [CNT_W-1:0] cnt_load,
   output logic [CNT_W-1:0] cnt_store,
   output logic [CNT_W-1:0] cnt_illegal
);

   localparam logic [6:0] c_op_alui  = 7'b0010011;
   localparam logic [6:0] c_op_load  = 7'b0000011;
   localparam logic [6:0] c_op_store = 7'b0100011;

   localparam logic [1:0] c_cls_alu     = 2'd0;
   localparam logic [1:0] c_cls_load    = 2'd1;
   localparam logic [1:0] c_cls_store   = 2'd2;
   localparam logic [1:0] c_cls_illegal = 2'd3;

   localparam logic [CNT_W-1:0] c_cnt_max = '1;

   typedef struct packed {
      logic [1:0]  cls;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic [31:0] imm;
   } rec_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } buf_state_t;

   generate
      if (BUF_DEPTH != 2) begin : g_bad_depth
         $error("ils_instr_decoder: BUF_DEPTH must be 2");
      end
   endgenerate

   buf_state_t            r_state;
   buf_state_t            w_state_nxt;
   rec_t                  r_head;
   rec_t                  r_tail;
   rec_t                  w_dec;
   logic [3:0][CNT_W-1:0] r_cnt;
   logic [1:0]            w_count;
   logic                  w_accept;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_head_from_in;
   logic                  w_head_from_tail;
   logic                  w_tail_from_in;
   logic [6:0]            w_op;
   logic [2:0]            w_f3;
   logic [6:0]            w_hi7;

   // ---------------------------------------------------------------------
   // Field decode (purely combinational on the incoming word)
   // ---------------------------------------------------------------------
   assign w_op  = in_instr[6:0];
   assign w_f3  = in_instr[14:12];
   assign w_hi7 = in_instr[31:25];

   // Illegal records keep the I-type layout so the raw fields stay visible.
   always_comb begin
      w_dec        = '0;
      w_dec.cls    = c_cls_illegal;
      w_dec.rd     = in_instr[11:7];
      w_dec.rs1    = in_instr[19:15];
      w_dec.rs2    = 5'd0;
      w_dec.funct3 = w_f3;
      w_dec.imm    = {{20{in_instr[31]}}, in_instr[31:20]};
      case (w_op)
         c_op_alui: begin
            if ((w_f3 == 3'd1 && w_hi7 != 7'b0000000) ||
                (w_f3 == 3'd5 && w_hi7 != 7'b0000000 && w_hi7 != 7'b0100000))
               w_dec.cls = c_cls_illegal;
            else
               w_dec.cls = c_cls_alu;
         end
         c_op_load: begin
            if (w_f3 == 3'd3 || w_f3 == 3'd6 || w_f3 == 3'd7)
               w_dec.cls = c_cls_illegal;
            else
               w_dec.cls = c_cls_load;
         end
         c_op_store: begin
            if (w_f3 <= 3'd2) begin
               w_dec.cls = c_cls_store;
               w_dec.rd  = 5'd0;
               w_dec.rs2 = in_instr[24:20];
               w_dec.imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
         end
         default: w_dec.cls = c_cls_illegal;
      endcase
   end

   // ---------------------------------------------------------------------
   // Handshake and buffer control
   // ---------------------------------------------------------------------
   always_comb begin
      case (r_state)
         ST_EMPTY: w_count = 2'd0;
         ST_ONE:   w_count = 2'd1;
         default:  w_count = 2'd2;
      endcase
   end

   assign in_ready  = (int'(w_count) < BUF_DEPTH);
   assign out_valid = (r_state != ST_EMPTY);
   assign w_accept  = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;

`ifdef ILS_DEC_NOP_FILTER_EN
   logic                  w_is_nop;
   logic [CNT_W-1:0]      r_cnt_nop;

   assign w_is_nop = (in_instr == 32'h0000_0013);
   assign w_push   = w_accept && !w_is_nop;
   assign cnt_nop  = r_cnt_nop;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_cnt_nop <= '0;
      else if (w_accept && w_is_nop && r_cnt_nop != c_cnt_max)
         r_cnt_nop <= r_cnt_nop + 1'b1;
   end
`else
   assign w_push = w_accept;
`endif

   // Slot 0 is always the head; slot 1 only ever holds the second record.
   always_comb begin
      w_state_nxt      = r_state;
      w_head_from_in   = 1'b0;
      w_head_from_tail = 1'b0;
      w_tail_from_in   = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_push) begin
               w_state_nxt    = ST_ONE;
               w_head_from_in = 1'b1;
            end
         end
         ST_ONE: begin
            case ({w_push, w_pop})
               2'b10: begin
                  w_state_nxt    = ST_TWO;
                  w_tail_from_in = 1'b1;
               end
               2'b01:   w_state_nxt    = ST_EMPTY;
               2'b11:   w_head_from_in = 1'b1;
               default: w_state_nxt    = ST_ONE;
            endcase
         end
         ST_TWO: begin
            if (w_pop) begin
               w_state_nxt      = ST_ONE;
               w_head_from_tail = 1'b1;
            end
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_EMPTY;
         r_head  <= '0;
         r_tail  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_head_from_in)
            r_head <= w_dec;
         else if (w_head_from_tail)
            r_head <= r_tail;
         if (w_tail_from_in)
            r_tail <= w_dec;
      end
   end

   // Retire counters advance on the pop, indexed by the departing class.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_cnt <= '0;
      else if (w_pop && r_cnt[r_head.cls] != c_cnt_max)
         r_cnt[r_head.cls] <= r_cnt[r_head.cls] + 1'b1;
   end

   assign out_class   = r_head.cls;
   assign out_rd      = r_head.rd;
   assign out_rs1     = r_head.rs1;
   assign out_rs2     = r_head.rs2;
   assign out_funct3  = r_head.funct3;
   assign out_imm     = r_head.imm;

   assign cnt_alu     = r_cnt[c_cls_alu];
   assign cnt_load    = r_cnt[c_cls_load];
   assign cnt_store   = r_cnt[c_cls_store];
   assign cnt_illegal = r_cnt[c_cls_illegal];

endmodule
`default_nettype wire

// File: tb/tb_ils_instr_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ils_instr_decoder
// Brief    : Scoreboard bench for ils_instr_decoder: directed scenarios plus
//            randomized traffic checked against a field-rule reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ils_instr_decoder;

   localparam int CNT_W = 3;
   localparam int C_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_instr;
   logic             out_valid;
   logic             out_ready;
   logic [1:0]       out_class;
   logic [4:0]       out_rd;
   logic [4:0]       out_rs1;
   logic [4:0]       out_rs2;
   logic [2:0]       out_funct3;
   logic [31:0]      out_imm;
   logic [CNT_W-1:0] cnt_alu;
   logic [CNT_W-1:0] cnt_load;
   logic [CNT_W-1:0] cnt_store;
   logic [CNT_W-1:0] cnt_illegal;
`ifdef ILS_DEC_NOP_FILTER_EN
   logic [CNT_W-1:0] cnt_nop;
`endif

   always #5 clk = ~clk;

   ils_instr_decoder #(.CNT_W(CNT_W), .BUF_DEPTH(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_instr    (in_instr),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_class   (out_class),
      .out_rd      (out_rd),
      .out_rs1     (out_rs1),
      .out_rs2     (out_rs2),
      .out_funct3  (out_funct3),
      .out_imm     (out_imm),
`ifdef ILS_DEC_NOP_FILTER_EN
      .cnt_nop     (cnt_nop),
`endif
      .cnt_alu     (cnt_alu),
      .cnt_load    (cnt_load),
      .cnt_store   (cnt_store),
      .cnt_illegal (cnt_illegal)
   );

   typedef struct {
      int          cls;
      int          rd;
      int          rs1;
      int          rs2;
      int          f3;
      logic [31:0] imm;
   } rec_t;

   rec_t exp_q[$];
   rec_t mon_e;
   int   m_cnt[4];
   int   m_nop;
   int   n_pops;
   int   n_checks;
   int   n_errors;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, req, $time);
      end
   endtask

   // Reference decode from the encoding rules, using plain integer arithmetic.
   function automatic rec_t model(input logic [31:0] w);
      rec_t r;
      int   op  = int'(w[6:0]);
      int   f3  = int'(w[14:12]);
      int   hi7 = int'(w[31:25]);
      int   v   = int'(w[31:20]);
      if (v >= 2048) v = v - 4096;
      r.rd  = int'(w[11:7]);
      r.rs1 = int'(w[19:15]);
      r.rs2 = 0;
      r.f3  = f3;
      if (op == 'h13)
         r.cls = ((f3 == 1 && hi7 != 0) || (f3 == 5 && hi7 != 0 && hi7 != 32)) ? 3 : 0;
      else if (op == 'h03)
         r.cls = (f3 == 3 || f3 == 6 || f3 == 7) ? 3 : 1;
      else if (op == 'h23)
         r.cls = (f3 > 2) ? 3 : 2;
      else
         r.cls = 3;
      if (r.cls == 2) begin
         r.rd  = 0;
         r.rs2 = int'(w[24:20]);
         v     = hi7 * 32 + int'(w[11:7]);
         if (v >= 2048) v = v - 4096;
      end
      r.imm = 32'(v);
      return r;
   endfunction

   function automatic logic [31:0] rand_word();
      logic [31:0] w   = $urandom;
      int          sel = $urandom_range(0, 9);
      if (sel <= 2)      w[6:0] = 7'h13;
      else if (sel <= 4) w[6:0] = 7'h03;
      else if (sel <= 6) w[6:0] = 7'h23;
      else if (sel == 8) w = 32'h0000_0013;
      else if (sel == 9) begin
         w[6:0]   = 7'h13;
         w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      end
      return w;
   endfunction

   // Monitor / scoreboard: sampled on the falling edge, away from updates.
   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
         m_cnt = '{0, 0, 0, 0};
         m_nop = 0;
      end else begin
         check("cnt_alu", 64'(cnt_alu), 64'(m_cnt[0]));
         check("cnt_load", 64'(cnt_load), 64'(m_cnt[1]));
         check("cnt_store", 64'(cnt_store), 64'(m_cnt[2]));
         check("cnt_illegal", 64'(cnt_illegal), 64'(m_cnt[3]));
`ifdef ILS_DEC_NOP_FILTER_EN
         check("cnt_nop", 64'(cnt_nop), 64'(m_nop));
`endif
         if (out_valid && out_ready) begin
            n_pops++;
            if (exp_q.size() == 0) begin
               check("unexpected_record", 64'(1), 64'(0));
            end else begin
               mon_e = exp_q.pop_front();
               check("rec_class", 64'(out_class), 64'(mon_e.cls));
               check("rec_rd", 64'(out_rd), 64'(mon_e.rd));
               check("rec_rs1", 64'(out_rs1), 64'(mon_e.rs1));
               check("rec_rs2", 64'(out_rs2), 64'(mon_e.rs2));
               check("rec_funct3", 64'(out_funct3), 64'(mon_e.f3));
               check("rec_imm", 64'(out_imm), 64'(mon_e.imm));
               if (m_cnt[mon_e.cls] < C_MAX) m_cnt[mon_e.cls]++;
            end
         end
         if (in_valid && in_ready) begin
`ifdef ILS_DEC_NOP_FILTER_EN
            if (in_instr == 32'h0000_0013) begin
               if (m_nop < C_MAX) m_nop++;
            end else
               exp_q.push_back(model(in_instr));
`else
            exp_q.push_back(model(in_instr));
`endif
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] w);
      bit done = 1'b0;
      in_valid = 1'b1;
      in_instr = w;
      for (int i = 0; i < 20 && !done; i++) begin
         done = in_ready;
         step();
      end
      in_valid = 1'b0;
      if (!done) check("send_timeout", 64'(0), 64'(1));
   endtask

   task automatic drain();
      bit empty = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 20 && !empty; i++) begin
         if (!out_valid) empty = 1'b1;
         else step();
      end
      if (!empty) check("drain_timeout", 64'(0), 64'(1));
   endtask

   initial begin
      int p0;
      n_checks  = 0;
      n_errors  = 0;
      n_pops    = 0;
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_instr  = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_in_ready", 64'(in_ready), 64'(1));
      check("rst_cnt_alu", 64'(cnt_alu), 64'(0));
      check("rst_cnt_illegal", 64'(cnt_illegal), 64'(0));
      check("rst_out_class", 64'(out_class), 64'(0));
      check("rst_out_imm", 64'(out_imm), 64'(0));
      check("rst_out_rd", 64'(out_rd), 64'(0));
      reset = 1'b0;
      step();

      // addi x6,x5,10: one-cycle latency, then the pop bumps cnt_alu
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_instr  = 32'h00A2_8313;
      step();
      in_valid = 1'b0;
      check("addi_valid", 64'(out_valid), 64'(1));
      check("addi_class", 64'(out_class), 64'(0));
      check("addi_rd", 64'(out_rd), 64'(6));
      check("addi_rs1", 64'(out_rs1), 64'(5));
      check("addi_imm", 64'(out_imm), 64'h0000_000A);
      step();
      check("addi_cnt_alu", 64'(cnt_alu), 64'(1));

      // sw x1,-4(x2)
      in_valid = 1'b1;
      in_instr = 32'hFE11_2E23;
      step();
      in_valid = 1'b0;
      check("sw_class", 64'(out_class), 64'(2));
      check("sw_rs1", 64'(out_rs1), 64'(2));
      check("sw_rs2", 64'(out_rs2), 64'(1));
      check("sw_funct3", 64'(out_funct3), 64'(2));
      check("sw_rd", 64'(out_rd), 64'(0));
      check("sw_imm", 64'(out_imm), 64'hFFFF_FFFC);
      drain();

      // Backpressure: two loads fill the buffer, the third waits
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'h0041_2083;
      step();
      in_instr = 32'h0081_2103;
      step();
      check("full_in_ready", 64'(in_ready), 64'(0));
      in_instr = 32'h0000_C183;
      step();
      check("full_hold_in_ready", 64'(in_ready), 64'(0));
      check("full_head_rd", 64'(out_rd), 64'(1));
      out_ready = 1'b1;
      step();
      check("after_pop_in_ready", 64'(in_ready), 64'(1));
      step();
      in_valid = 1'b0;
      drain();
      check("loads_cnt_load", 64'(cnt_load), 64'(3));

      // Illegal encodings
      send(32'h0202_9293);
      send(32'h0000_3303);
      send(32'h0000_007F);
      drain();
      check("illegal_cnt", 64'(cnt_illegal), 64'(3));

      // Asynchronous reset with a full buffer
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'h00A2_8313;
      step();
      in_instr = 32'hFE11_2E23;
      step();
      in_valid = 1'b0;
      check("pre_rst_full", 64'(in_ready), 64'(0));
      reset = 1'b1;
      #1;
      check("arst_out_valid", 64'(out_valid), 64'(0));
      check("arst_cnt_alu", 64'(cnt_alu), 64'(0));
      check("arst_cnt_load", 64'(cnt_load), 64'(0));
      check("arst_cnt_illegal", 64'(cnt_illegal), 64'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;
      step();
      check("post_rst_in_ready", 64'(in_ready), 64'(1));

      // NOP stream
      out_ready = 1'b1;
      p0 = n_pops;
      in_valid = 1'b1;
      in_instr = 32'h0000_0013;
      step();
      step();
      in_instr = 32'h00A2_8313;
      step();
      in_valid = 1'b0;
      drain();
`ifdef ILS_DEC_NOP_FILTER_EN
      check("nop_records", 64'(n_pops - p0), 64'(1));
      check("nop_cnt_nop", 64'(cnt_nop), 64'(2));
      check("nop_cnt_alu", 64'(cnt_alu), 64'(1));
`else
      check("nop_records", 64'(n_pops - p0), 64'(3));
      check("nop_cnt_alu", 64'(cnt_alu), 64'(3));
`endif

      // Randomized traffic; counters saturate at this CNT_W
      for (int i = 0; i < 1500; i++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         in_instr  = rand_word();
         out_ready = ($urandom_range(0, 9) < 6);
         step();
      end
      in_valid = 1'b0;
      drain();
      step();
      check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
